instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/loader_pkg.sv | 17 +
 rtl/word_packer.sv | 39 +++
 rtl/instr_loader.sv | 119 +++++++++++
 tb/tb_instr_loader.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction loader: FSM state encoding
// and the default program terminator word.
package loader_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;

    localparam logic [WORD_W-1:0] TERM_DEFAULT = 32'hffff_ffff;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } state_e;

endpackage

// File: rtl/word_packer.sv
// Assembles four bytes, most significant first, into a 32-bit word.
// 'word' shows the register value including a byte being shifted in this cycle.
module word_packer
    import loader_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              shift_en,
    input  logic [BYTE_W-1:0] byte_data,
    output logic [WORD_W-1:0] word,
    output logic              word_full
);

    logic [1:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] word_q, word_d;

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (shift_en) begin
            cnt_d  = cnt_q + 2'd1;
            word_d = {word_q[WORD_W-BYTE_W-1:0], byte_data};
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign word      = word_d;
    assign word_full = shift_en && (cnt_q == 2'd3);

endmodule

// File: rtl/instr_loader.sv
// Streams a byte-serial program into instruction memory word by word and
// holds the CPU in reset until the terminator word has been written.
module instr_loader
    import loader_pkg::*;
#(
    parameter int unsigned       ADDR_W = 8,
    parameter logic [WORD_W-1:0] TERM   = TERM_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic [ADDR_W:0]   words_loaded,
    output logic              done,
    output logic              error,
    output logic              cpu_rst_n
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_e            state_q, state_d;
    logic              active_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0] wr_data_q, wr_data_d;
    logic [ADDR_W:0]   count_q, count_d;

    logic              accept;
    logic              word_full;
    logic [WORD_W-1:0] word;

    assign accept = byte_valid && byte_ready;

    word_packer u_packer (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .shift_en  (accept),
        .byte_data (byte_data),
        .word      (word),
        .word_full (word_full)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD:  if (word_full) state_d = WRITE;
            WRITE: begin
                if (wr_data_q == TERM) begin
                    state_d = DONE;
                end else if (wr_addr_q == LAST_ADDR) begin
                    state_d = ERROR;
                end else begin
                    state_d = LOAD;
                end
            end
            DONE:  state_d = DONE;
            ERROR: state_d = ERROR;
            default: state_d = LOAD;
        endcase
    end

    // active_q keeps byte_ready low until the first edge with RST_N sampled high.
    always_comb begin
        byte_ready = (state_q == LOAD) && active_q && RST_N;
        wr_en      = (state_q == WRITE);
        done       = (state_q == DONE);
        error      = (state_q == ERROR);
        cpu_rst_n  = (state_q == DONE);
    end

    // Write address/data are captured on the 4th byte so they stay stable between writes.
    always_comb begin
        addr_d    = addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        count_d   = count_q;
        if ((state_q == LOAD) && word_full) begin
            wr_addr_d = addr_q;
            wr_data_d = word;
        end
        if (state_q == WRITE) begin
            addr_d  = addr_q + ADDR_W'(1);
            count_d = count_q + (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            active_q  <= 1'b0;
            addr_q    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            count_q   <= '0;
        end else begin
            active_q  <= 1'b1;
            addr_q    <= addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            count_q   <= count_d;
        end
    end

    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign words_loaded = count_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: one instance at the default address width
// and one at ADDR_W=2 for memory-full and last-address terminator cases.
module tb_instr_loader;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RST_N;
    logic       sel;
    logic       valid;
    logic [7:0] data;

    logic        r8, we8, d8, e8, c8;
    logic [7:0]  wa8;
    logic [31:0] wd8;
    logic [8:0]  wl8;

    logic        r2, we2, d2, e2, c2;
    logic [1:0]  wa2;
    logic [31:0] wd2;
    logic [2:0]  wl2;

    logic v8, v2;
    assign v8 = valid && !sel;
    assign v2 = valid && sel;

    instr_loader #(.ADDR_W(8)) dut8 (
        .CLK(CLK), .RST_N(RST_N), .byte_valid(v8), .byte_data(data),
        .byte_ready(r8), .wr_en(we8), .wr_addr(wa8), .wr_data(wd8),
        .words_loaded(wl8), .done(d8), .error(e8), .cpu_rst_n(c8)
    );

    instr_loader #(.ADDR_W(2), .TERM(32'hffff_ffff)) dut2 (
        .CLK(CLK), .RST_N(RST_N), .byte_valid(v2), .byte_data(data),
        .byte_ready(r2), .wr_en(we2), .wr_addr(wa2), .wr_data(wd2),
        .words_loaded(wl2), .done(d2), .error(e2), .cpu_rst_n(c2)
    );

    logic        m_ready, m_we, m_done, m_err, m_cpu;
    logic [7:0]  m_wa;
    logic [31:0] m_wd;
    logic [8:0]  m_wl;
    assign m_ready = sel ? r2 : r8;
    assign m_we    = sel ? we2 : we8;
    assign m_done  = sel ? d2 : d8;
    assign m_err   = sel ? e2 : e8;
    assign m_cpu   = sel ? c2 : c8;
    assign m_wa    = sel ? {6'd0, wa2} : wa8;
    assign m_wd    = sel ? wd2 : wd8;
    assign m_wl    = sel ? {6'd0, wl2} : wl8;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int          q_addr[$];
    logic [31:0] q_data[$];
    int unsigned q_cyc[$];
    logic        q_rdy[$];

    always @(negedge CLK) begin
        if (m_we === 1'b1) begin
            q_addr.push_back(int'(m_wa));
            q_data.push_back(m_wd);
            q_cyc.push_back(cyc);
            q_rdy.push_back(m_ready);
        end
    end

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned last_acc = 0;
    int unsigned w1_acc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic clear_log();
        q_addr.delete();
        q_data.delete();
        q_cyc.delete();
        q_rdy.delete();
    endtask

    task automatic do_reset();
        valid = 1'b0;
        RST_N = 1'b0;
        idle(1);
        RST_N = 1'b1;
        idle(1);
    endtask

    // Holds the byte until an edge where byte_ready is high; bounded wait.
    task automatic put(input logic [7:0] b);
        int unsigned n = 0;
        valid = 1'b1;
        data  = b;
        @(negedge CLK);
        while (m_ready !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (m_ready !== 1'b1) chk("put_timeout", 0, 1);
        last_acc = cyc;
        @(posedge CLK);
        #1;
        valid = 1'b0;
    endtask

    task automatic put_word(input logic [31:0] w, input int unsigned gap);
        for (int i = 3; i >= 0; i--) begin
            put(w[i*8 +: 8]);
            if (gap != 0) idle(gap);
        end
    endtask

    task automatic chk_wr(input int unsigned i, input int exp_addr, input logic [31:0] exp_data);
        int          a = -1;
        logic [31:0] d = 32'hdead_beef;
        logic        r = 1'b1;
        if (i < q_addr.size()) begin
            a = q_addr[i];
            d = q_data[i];
            r = q_rdy[i];
        end
        chk($sformatf("wr%0d_addr", i), 64'(a), 64'(exp_addr));
        chk($sformatf("wr%0d_data", i), 64'(d), 64'(exp_data));
        chk($sformatf("wr%0d_ready", i), 64'(r), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] gap_words [4];
    logic [31:0] full_words [4];

    initial begin
        gap_words  = '{32'h11223344, 32'h55667788, 32'h99aabbcc, 32'hffffffff};
        full_words = '{32'h0a0b0c0d, 32'h10203040, 32'h50607080, 32'h90a0b0c0};
        sel   = 1'b0;
        valid = 1'b0;
        data  = 8'h00;
        RST_N = 1'b0;
        idle(3);

        chk("rst_ready", m_ready, 0);
        chk("rst_wr_en", m_we, 0);
        chk("rst_wr_addr", m_wa, 0);
        chk("rst_wr_data", m_wd, 0);
        chk("rst_words", m_wl, 0);
        chk("rst_done", m_done, 0);
        chk("rst_error", m_err, 0);
        chk("rst_cpu_rst_n", m_cpu, 0);

        RST_N = 1'b1;
        @(negedge CLK);
        chk("ready_before_sample", m_ready, 0);
        @(posedge CLK);
        #1;
        chk("ready_after_release", m_ready, 1);

        // Gap-free program: one word plus terminator
        clear_log();
        put_word(32'h20080005, 0);
        w1_acc = last_acc;
        put_word(32'hffffffff, 0);
        idle(2);
        chk("a_writes", q_addr.size(), 2);
        chk_wr(0, 0, 32'h20080005);
        chk("a_latency", (q_cyc.size() > 0) ? q_cyc[0] : 0, w1_acc + 1);
        chk_wr(1, 1, 32'hffffffff);
        chk("a_done", m_done, 1);
        chk("a_error", m_err, 0);
        chk("a_cpu_rst_n", m_cpu, 1);
        chk("a_words", m_wl, 2);
        chk("a_ready", m_ready, 0);

        // Bytes offered after done are ignored
        clear_log();
        valid = 1'b1;
        data  = 8'h5a;
        idle(10);
        valid = 1'b0;
        chk("post_done_writes", q_addr.size(), 0);
        chk("post_done_done", m_done, 1);
        chk("post_done_words", m_wl, 2);
        chk("post_done_addr", m_wa, 1);
        chk("post_done_data", m_wd, 32'hffffffff);
        chk("post_done_cpu", m_cpu, 1);
        RST_N = 1'b0;
        idle(1);
        chk("done_rst_cpu", m_cpu, 0);
        chk("done_rst_done", m_done, 0);
        RST_N = 1'b1;
        idle(1);

        // byte_valid toggling every other cycle
        do_reset();
        clear_log();
        for (int i = 0; i < 4; i++) put_word(gap_words[i], 1);
        idle(2);
        chk("b_writes", q_addr.size(), 4);
        for (int i = 0; i < 4; i++) chk_wr(i, i, gap_words[i]);
        chk("b_done", m_done, 1);
        chk("b_words", m_wl, 4);

        // Reset after two bytes discards them
        do_reset();
        clear_log();
        put(8'h12);
        put(8'h34);
        do_reset();
        put_word(32'habcdef01, 0);
        idle(2);
        chk("c_writes", q_addr.size(), 1);
        chk_wr(0, 0, 32'habcdef01);
        chk("c_words", m_wl, 1);
        chk("c_done", m_done, 0);

        // Reset coinciding with the 4th byte suppresses the write
        do_reset();
        clear_log();
        put(8'h01);
        put(8'h02);
        put(8'h03);
        valid = 1'b1;
        data  = 8'h04;
        RST_N = 1'b0;
        @(negedge CLK);
        chk("ready_in_reset", m_ready, 0);
        @(posedge CLK);
        #1;
        valid = 1'b0;
        RST_N = 1'b1;
        idle(3);
        chk("c2_writes", q_addr.size(), 0);
        chk("c2_words", m_wl, 0);
        chk("c2_data", m_wd, 0);

        // ADDR_W=2: memory fills without terminator
        sel = 1'b1;
        do_reset();
        clear_log();
        for (int i = 0; i < 4; i++) put_word(full_words[i], 0);
        idle(2);
        chk("d_writes", q_addr.size(), 4);
        for (int i = 0; i < 4; i++) chk_wr(i, i, full_words[i]);
        chk("d_error", m_err, 1);
        chk("d_done", m_done, 0);
        chk("d_cpu_rst_n", m_cpu, 0);
        chk("d_ready", m_ready, 0);
        chk("d_words", m_wl, 4);
        valid = 1'b1;
        idle(5);
        valid = 1'b0;
        chk("d_sticky_error", m_err, 1);
        chk("d_sticky_writes", q_addr.size(), 4);

        // ADDR_W=2: terminator lands on the last address
        do_reset();
        clear_log();
        for (int i = 0; i < 3; i++) put_word(full_words[i], 0);
        put_word(32'hffffffff, 0);
        idle(2);
        chk("e_writes", q_addr.size(), 4);
        chk_wr(3, 3, 32'hffffffff);
        chk("e_done", m_done, 1);
        chk("e_error", m_err, 0);
        chk("e_cpu_rst_n", m_cpu, 1);
        chk("e_words", m_wl, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
